// File: rtl/instruction_encoder.sv
// RV32I instruction word assembler: packs decoded fields back into a 32-bit encoding
// and expands the li pseudo-op into ADDI, LUI, or LUI+ADDI behind a one-entry output register.
module instruction_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_li,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        enc_err
);

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode_t;

  typedef enum logic {IDLE, SECOND} state_t;

  state_t      state_q, state_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic        enc_err_q, enc_err_d;
  logic [31:0] pend_q, pend_d;

  logic        accept, consume;
  logic        i_ok, b_ok, j_ok;
  logic [31:0] enc_word;
  logic        enc_bad;
  logic [11:0] lo;
  logic [19:0] hi;
  logic [31:0] li_first, li_second;
  logic        li_two;

  assign accept  = req_valid && req_ready;
  assign consume = out_valid_q && out_ready;

  // Range checks reduce to "all bits above the field are copies of the sign bit"
  assign i_ok = (imm[31:11] == '0) || (imm[31:11] == '1);
  assign b_ok = ((imm[31:12] == '0) || (imm[31:12] == '1)) && !imm[0];
  assign j_ok = ((imm[31:20] == '0) || (imm[31:20] == '1)) && !imm[0];

  always_comb begin
    enc_word = '0;
    enc_bad  = 1'b0;
    case (opcode)
      op_lui, op_auipc: begin
        enc_word = {imm[31:12], rd, opcode};
        enc_bad  = (imm[11:0] != 12'd0);
      end
      op_jal: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        enc_bad  = !j_ok;
      end
      op_jalr, op_load, op_csr: begin
        enc_word = {imm[11:0], rs1, funct3, rd, opcode};
        enc_bad  = !i_ok;
      end
      op_imm: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          enc_word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
          enc_bad  = (imm[31:5] != '0);
        end else begin
          enc_word = {imm[11:0], rs1, funct3, rd, opcode};
          enc_bad  = !i_ok;
        end
      end
      op_br: begin
        enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        enc_bad  = !b_ok;
      end
      op_store: begin
        enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        enc_bad  = !i_ok;
      end
      op_reg: begin
        enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
      end
      default: begin
        enc_bad = 1'b1;
      end
    endcase
  end

  // hi rounds up when lo is negative as a signed 12-bit value, so LUI+ADDI sums back to imm
  assign lo        = imm[11:0];
  assign hi        = imm[31:12] + {19'd0, imm[11]};
  assign li_first  = i_ok ? {lo, 5'd0, 3'b000, rd, op_imm} : {hi, rd, op_lui};
  assign li_second = {lo, rd, 3'b000, rd, op_imm};
  assign li_two    = !i_ok && (lo != 12'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      enc_err_q   <= 1'b0;
      pend_q      <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      enc_err_q   <= enc_err_d;
      pend_q      <= pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    enc_err_d   = 1'b0;
    pend_d      = pend_q;
    if (consume) out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_li) begin
            out_valid_d = 1'b1;
            out_instr_d = li_first;
            if (li_two) begin
              pend_d  = li_second;
              state_d = SECOND;
            end
          end else if (enc_bad) begin
            enc_err_d = 1'b1;
          end else begin
            out_valid_d = 1'b1;
            out_instr_d = enc_word;
          end
        end
      end
      SECOND: begin
        if (consume) begin
          out_valid_d = 1'b1;
          out_instr_d = pend_q;
          pend_d      = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
    out_valid = out_valid_q;
    out_instr = out_instr_q;
    enc_err   = enc_err_q;
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Scoreboard bench for instruction_encoder: directed requests push hand-computed words,
// a negedge monitor pops and compares every consumed output word and counts error pulses.
module tb_instruction_encoder;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_li;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        enc_err;

  int          total;
  int          bad;
  int          err_seen;
  int          err_exp;
  logic [31:0] exp_q[$];

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_REG   = 7'b0110011;

  instruction_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_li    (req_li),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .enc_err   (enc_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h", name, actual, expected);
    end
  endtask

  // Issues one request, waits (bounded) for acceptance, then records what should come out
  task automatic applyStimulus(input logic li, input logic [6:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [4:0] a1, input logic [4:0] a2,
                               input logic [4:0] d, input logic [31:0] im, input int n,
                               input logic [31:0] w0, input logic [31:0] w1, input logic e);
    int waited;
    req_li = li; opcode = op; funct3 = f3; funct7 = f7;
    rs1 = a1; rs2 = a2; rd = d; imm = im;
    req_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("accept", {31'd0, req_ready}, 32'd1);
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (n >= 1) exp_q.push_back(w0);
    if (n >= 2) exp_q.push_back(w1);
    if (e) err_exp++;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (enc_err) err_seen++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_word got=%h want=none", out_instr);
        end else begin
          checkOutput("out_instr", out_instr, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    total = 0; bad = 0; err_seen = 0; err_exp = 0;
    rst = 1'b1; req_valid = 1'b0; req_li = 1'b0; out_ready = 1'b0;
    opcode = '0; funct3 = '0; funct7 = '0; rs1 = '0; rs2 = '0; rd = '0; imm = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_out_instr", out_instr, 32'd0);
    checkOutput("rst_enc_err", {31'd0, enc_err}, 32'd0);
    checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;

    applyStimulus(0, OPC_IMM,   3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'd5,          1, 32'h00500093, 0, 0);
    applyStimulus(0, OPC_BR,    3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'd8,          1, 32'h00208463, 0, 0);
    applyStimulus(0, OPC_BR,    3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'd3,          0, 0, 0, 1);
    applyStimulus(0, OPC_BR,    3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'd4094,       1, 32'h7E208FE3, 0, 0);
    applyStimulus(0, OPC_BR,    3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'hFFFFF000,   1, 32'h80208063, 0, 0);
    applyStimulus(0, OPC_BR,    3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'd4096,       0, 0, 0, 1);
    applyStimulus(0, OPC_LUI,   3'd0, 7'h00, 5'd0, 5'd0, 5'd3, 32'hABCDE000,   1, 32'hABCDE1B7, 0, 0);
    applyStimulus(0, OPC_LUI,   3'd0, 7'h00, 5'd0, 5'd0, 5'd3, 32'hABCDE001,   0, 0, 0, 1);
    applyStimulus(0, OPC_JAL,   3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'd2048,       1, 32'h001000EF, 0, 0);
    applyStimulus(0, OPC_JAL,   3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC,   1, 32'hFFDFF06F, 0, 0);
    applyStimulus(0, OPC_JAL,   3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd5,          0, 0, 0, 1);
    applyStimulus(0, OPC_JALR,  3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd0,          1, 32'h00008067, 0, 0);
    applyStimulus(0, OPC_STORE, 3'd2, 7'h00, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFC,   1, 32'hFE20AE23, 0, 0);
    applyStimulus(0, OPC_REG,   3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 32'd0,          1, 32'h402081B3, 0, 0);
    applyStimulus(0, OPC_IMM,   3'd1, 7'h00, 5'd1, 5'd0, 5'd1, 32'd3,          1, 32'h00309093, 0, 0);
    applyStimulus(0, OPC_IMM,   3'd5, 7'h20, 5'd1, 5'd0, 5'd1, 32'd31,         1, 32'h41F0D093, 0, 0);
    applyStimulus(0, OPC_IMM,   3'd1, 7'h00, 5'd1, 5'd0, 5'd1, 32'd32,         0, 0, 0, 1);
    applyStimulus(0, OPC_IMM,   3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'd2048,       0, 0, 0, 1);
    applyStimulus(0, OPC_IMM,   3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'hFFFFF800,   1, 32'h80000093, 0, 0);
    applyStimulus(0, 7'h7F,     3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'd0,          0, 0, 0, 1);

    // Two-word li: the encoder must refuse new requests while the ADDI is pending
    applyStimulus(1, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd5, 32'h12345678, 2, 32'h123452B7, 32'h67828293, 0);
    @(negedge clk);
    checkOutput("second_req_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(1, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd5, 32'h00000800, 2, 32'h000012B7, 32'h80028293, 0);
    applyStimulus(1, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd5, 32'h00003000, 1, 32'h000032B7, 0, 0);
    applyStimulus(1, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd5, 32'hFFFFFFFF, 1, 32'hFFF00293, 0, 0);
    applyStimulus(1, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd5, 32'h7FFFF800, 2, 32'h800002B7, 32'h80028293, 0);

    repeat (4) @(posedge clk);
    #1;
    out_ready = 1'b0;
    applyStimulus(0, OPC_IMM, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'd5, 1, 32'h00500093, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp_out_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("bp_out_instr", out_instr, 32'h00500093);
      checkOutput("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    checkOutput("bp_drained", {31'd0, out_valid}, 32'd0);

    // Reset while the ADDI half is pending must discard both words
    out_ready = 1'b0;
    applyStimulus(1, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd5, 32'h12345678, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("mid_first_word", out_instr, 32'h123452B7);
    checkOutput("mid_req_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
    checkOutput("err_pulses", 32'(err_seen), 32'(err_exp));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_encoder.md
# instruction_encoder

Assembles RV32I instruction words from decoded fields, the inverse of the instruction-register field extraction. Also expands the `li rd, imm32` pseudo-instruction into one or two words. It feeds test-program loaders and micro-op expansion paths that must write legal encodings into instruction memory or the fetch queue. Input and output are valid/ready handshakes with a single registered output entry.

## Interface
- No parameters.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_li  in  1  1: li pseudo-op, uses rd/imm only; 0: literal encode
- opcode  in  7  rv32i_opcode_t value
- funct3  in  3  funct3 field
- funct7  in  7  funct7 field (R-type, shift-immediates)
- rs1, rs2, rd  in  5 each  register indices
- imm  in  32  full signed byte-offset / immediate value, not pre-shifted
- out_valid  out  1  out_instr holds a word
- out_ready  in  1  consumer takes word when out_valid && out_ready
- out_instr  out  32  encoded instruction
- enc_err  out  1  one-cycle pulse: last accepted request was unencodable, nothing emitted

## Operation
- Format by opcode:
  - U: op_lui, op_auipc
  - J: op_jal
  - I: op_jalr, op_load, op_imm, op_csr
  - B: op_br
  - S: op_store
  - R: op_reg
- Any other opcode triggers an error.
- Legality checks; a violation triggers an error:
  - I/S: imm in [-2048, 2047].
  - B: imm in [-4096, 4094] and imm[0]=0.
  - J: imm in [-2^20, 2^20-2] and imm[0]=0.
  - U: imm[11:0]=0; field = imm[31:12].
  - R: imm ignored.
- Shift-immediates (op_imm with funct3 001/101): [31:25]=funct7, [24:20]=imm[4:0]. Requires imm in [0,31], else error.
- Bit placement is the exact inverse of the i/s/b/u/j immediate extraction:
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
- Unused register fields are driven from the inputs regardless of format: rs1/rs2/rd/funct3 are placed wherever the format has them.
- li expansion, with lo=imm[11:0] and hi=(imm+0x800)[31:12]:
  - imm in [-2048,2047]: one word, ADDI rd,x0,lo.
  - else if lo=0: one word, LUI rd,hi.
  - else two words: LUI rd,hi, then ADDI rd,rd,lo.
  - li never errors.
- FSM states:
  - IDLE: normal operation.
  - SECOND: first li word sits in the output register; the ADDI is pending internally.
- Transitions:
  - IDLE→SECOND on acceptance of a two-word li.
  - SECOND→IDLE when the first word is consumed; the ADDI is loaded into the output register the same edge.
- Error requests are accepted normally (the handshake completes). The output register is untouched, and enc_err=1 the following cycle only.

## Timing
- Reset values: state IDLE, out_valid=0, out_instr=0, enc_err=0, pending word=0.
- req_ready = (state==IDLE) && (!out_valid || out_ready). It is combinational and allows back-to-back throughput of one word per cycle.
- Latency: a word accepted at edge N is presented with out_valid=1 after edge N (visible in cycle N+1).
- Second li word: appears the cycle after the first is consumed, so a two-word li occupies two output cycles minimum. req_ready=0 throughout SECOND.
- Output stability: out_instr is stable and out_valid stays high while out_valid && !out_ready.
- out_valid falls after consumption unless a new word loads on the same edge.
- enc_err does not block the handshake. An error request accepted while the output drains causes out_valid to drop after the drain.
- Reset mid-operation: rst in SECOND drops both words and returns to IDLE with out_valid=0 next cycle.

## Test plan
- addi x1,x0,5 (op_imm, f3=0, rd=1, rs1=0, imm=5), out_ready=1 → out_instr=0x00500093 one cycle after accept.
- beq x1,x2,+8 (op_br, imm=8) → 0x00208463. Same with imm=3 → no out_valid, enc_err pulses once.
- li x5,0x12345678 → 0x123452B7 then 0x67828293 on consecutive cycles; req_ready=0 during SECOND.
- li x5,0x00000800 → 0x000012B7, 0x80028293. li x5,0x00003000 → single 0x000032B7.
- Backpressure: hold out_ready=0 for 3 cycles after addi accept → out_instr stable at 0x00500093, req_ready=0, then consumed on the 4th cycle.
- Assert rst while in SECOND of li x5,0x12345678 → next cycle out_valid=0, req_ready=1, and 0x67828293 is never emitted.
